// File: rtl/cram_pkg.sv
// Shared types and CRC helper for the configuration RAM loader.
package cram_pkg;

   localparam int         CRC_LEN  = 8;
   localparam logic [7:0] CRC_POLY = 8'h07;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_VERIFY = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERROR  = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_CRC    = 2'd1,
      ERR_VERIFY = 2'd2,
      ERR_ABORT  = 2'd3
   } err_code_e;

   // One bit of an MSB-first CRC-8 (poly 0x07) update.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
      logic fb;
      fb = crc[7] ^ din;
      return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/cram_crc8.sv
// CRC-8 accumulator absorbing NUM_CHAINS bits per enabled cycle, highest bit first.
module cram_crc8
   import cram_pkg::*;
#(
   parameter int NUM_CHAINS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  en,
   input  logic [NUM_CHAINS-1:0] din,
   output logic [7:0]            crc
);

   logic [7:0] crc_q;
   logic [7:0] crc_d;

   // Next CRC: clear wins over absorbing a word.
   always_comb begin
      crc_d = crc_q;
      if (clr) begin
         crc_d = '0;
      end else if (en) begin
         for (int i = NUM_CHAINS - 1; i >= 0; i--) begin
            crc_d = crc8_step(crc_d, din[i]);
         end
      end
   end

   // CRC register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/cram_loader.sv
// Configuration RAM loader: shifts a stream into parallel config chains (LOAD)
// or recirculates them while comparing against the stream (VERIFY), then
// checks a CRC over the stream.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | after reset, waiting for start
// ST_LOAD   | shifting s_data into the chains
// ST_VERIFY | recirculating chains, comparing tail bits to s_data
// ST_CHECK  | one cycle: compare CRC and mismatch flag
// ST_DONE   | operation succeeded; done held until next start
// ST_ERROR  | operation failed or aborted; err held until next start
module cram_loader
   import cram_pkg::*;
#(
   parameter int NUM_CHAINS = 4,
   parameter int CHAIN_LEN  = 109,
   parameter int CRC_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [CRC_W-1:0]      exp_crc,
   input  logic                  abort,
   input  logic [NUM_CHAINS-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  cfg_en,
   output logic                  cfg_shift,
   output logic [NUM_CHAINS-1:0] cfg_data_in,
   input  logic [NUM_CHAINS-1:0] cfg_data_out,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [1:0]            err_code
);

   localparam int              CNT_W = $clog2(CHAIN_LEN + 1);
   localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mism_q, mism_d;
   err_code_e        err_code_q, err_code_d;
   logic [CRC_W-1:0] exp_crc_q, exp_crc_d;

   logic             active;
   logic             idle_like;
   logic             start_ok;
   logic             xfer;
   logic             cmp_bad;
   logic             crc_clr;
   logic [CRC_W-1:0] crc;

   // Stream-facing qualifiers; s_ready depends on state and count only.
   always_comb begin
      active    = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
      idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
      s_ready   = active && (cnt_q < LEN);
      // abort suppresses the shift even though s_ready may be high
      xfer      = s_ready && s_valid && !abort;
      start_ok  = start && !abort && idle_like;
      cmp_bad   = (state_q == ST_VERIFY) && xfer && (cfg_data_out != s_data);
   end

   // Serial data into the chains: stream in LOAD, recirculated tail in VERIFY.
   always_comb begin
      cfg_data_in = '0;
      if (state_q == ST_LOAD) begin
         cfg_data_in = s_data;
      end else if (state_q == ST_VERIFY) begin
         cfg_data_in = cfg_data_out;
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mism_d     = mism_q;
      err_code_d = err_code_q;
      exp_crc_d  = exp_crc_q;
      crc_clr    = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start_ok) begin
               state_d    = mode ? ST_VERIFY : ST_LOAD;
               cnt_d      = '0;
               mism_d     = 1'b0;
               err_code_d = ERR_NONE;
               exp_crc_d  = exp_crc;
               crc_clr    = 1'b1;
            end
         end
         ST_LOAD, ST_VERIFY: begin
            if (abort) begin
               state_d    = ST_ERROR;
               err_code_d = ERR_ABORT;
            end else begin
               if (xfer) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (cmp_bad) begin
                  mism_d = 1'b1;
               end
               // last word moves straight on so CHECK follows it immediately
               if (cnt_d >= LEN) begin
                  state_d = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            if (abort) begin
               state_d    = ST_ERROR;
               err_code_d = ERR_ABORT;
            end else if ((crc == exp_crc_q) && !mism_q) begin
               state_d = ST_DONE;
            end else begin
               state_d    = ST_ERROR;
               err_code_d = mism_q ? ERR_VERIFY : ERR_CRC;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         mism_q     <= 1'b0;
         err_code_q <= ERR_NONE;
         exp_crc_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mism_q     <= mism_d;
         err_code_q <= err_code_d;
         exp_crc_q  <= exp_crc_d;
      end
   end

   cram_crc8 #(
      .NUM_CHAINS(NUM_CHAINS)
   ) u_crc (
      .clk (clk),
      .rst (rst),
      .clr (crc_clr),
      .en  (xfer),
      .din (s_data),
      .crc (crc)
   );

   // Status and chain control decoded from the registered state.
   always_comb begin
      cfg_en    = active;
      cfg_shift = xfer;
      busy      = active || (state_q == ST_CHECK);
      done      = (state_q == ST_DONE);
      err       = (state_q == ST_ERROR);
      err_code  = err_code_q;
   end

endmodule

// File: tb/tb_cram_loader.sv
module tb_cram_loader;

   localparam int NC = 4;
   localparam int CL = 109;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          mode;
   logic [7:0]    exp_crc;
   logic          abort;
   logic [NC-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic          cfg_en;
   logic          cfg_shift;
   logic [NC-1:0] cfg_data_in;
   logic [NC-1:0] cfg_data_out;
   logic          busy;
   logic          done;
   logic          err;
   logic [1:0]    err_code;

   always #5 clk = ~clk;

   cram_loader #(
      .NUM_CHAINS(NC),
      .CHAIN_LEN (CL),
      .CRC_W     (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .mode         (mode),
      .exp_crc      (exp_crc),
      .abort        (abort),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .cfg_en       (cfg_en),
      .cfg_shift    (cfg_shift),
      .cfg_data_in  (cfg_data_in),
      .cfg_data_out (cfg_data_out),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .err_code     (err_code)
   );

   // Chain model: one CL-bit shift register per chain, tail = MSB.
   logic [CL-1:0] chain [NC];
   always @(posedge clk) begin
      if (cfg_en && cfg_shift) begin
         for (int k = 0; k < NC; k++) chain[k] <= {chain[k][CL-2:0], cfg_data_in[k]};
      end
   end
   always_comb begin
      for (int k = 0; k < NC; k++) cfg_data_out[k] = chain[k][CL-1];
   end

   int            n_cmp = 0;
   int            n_fail = 0;
   int            shift_cnt = 0;
   logic [NC-1:0] exp_in_q [$];
   logic [3:0]    exp_stat_q [$];   // {done, err, err_code}
   logic [NC-1:0] strm   [CL];
   logic [NC-1:0] loaded [CL];
   logic [CL-1:0] snap   [NC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] crc_strm();
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      for (int i = 0; i < CL; i++) begin
         for (int b = NC - 1; b >= 0; b--) begin
            fb = c[7] ^ strm[i][b];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
         end
      end
      return c;
   endfunction

   function automatic logic chains_match();
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < NC; k++) if (chain[k] !== snap[k]) ok = 1'b0;
      return ok;
   endfunction

   // stop_kind: 0 run to completion, 1 abort at word stop_at, 2 rst at word stop_at
   task automatic run_op(input logic m, input logic [7:0] ec, input logic [3:0] stat,
                         input int every, input int stop_at, input int stop_kind,
                         output int cycles);
      int base;
      int i;
      int cyc;
      int w;
      base = shift_cnt;
      if (stop_kind != 2) exp_stat_q.push_back(stat);
      start = 1'b1; mode = m; exp_crc = ec;
      @(posedge clk); #1;
      start = 1'b0;
      i = 0; cyc = 1;
      while (i < CL && cyc < 1000) begin
         if (stop_kind != 0 && i == stop_at) break;
         s_valid = (every == 1) || (cyc % 2 == 0);
         s_data  = strm[i];
         if (s_valid && s_ready) begin
            exp_in_q.push_back(m ? loaded[i] : strm[i]);
            if (!m) loaded[i] = strm[i];
            i++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      s_valid = 1'b0;
      if (stop_kind == 1) begin
         abort = 1'b1; s_valid = 1'b1; s_data = strm[i];
         @(posedge clk); #1;
         abort = 1'b0; s_valid = 1'b0;
         chk("abort_err_next_cycle", {29'd0, err, err_code}, 32'h7);
         chk("abort_shift_count", shift_cnt - base, stop_at);
      end else if (stop_kind == 2) begin
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         chk("rst_mid_load_outputs",
             {25'd0, busy, done, err, err_code, cfg_en, cfg_shift, s_ready}, 32'h0);
         chk("rst_shift_count", shift_cnt - base, stop_at);
      end else begin
         chk("check_state_flags", {29'd0, busy, cfg_en, s_ready}, 32'h4);
         w = 0;
         while (!(done || err) && w < 8) begin
            @(posedge clk); #1;
            w++; cyc++;
         end
         chk("check_lasts_one_cycle", w, 1);
         chk("shift_count", shift_cnt - base, CL);
      end
      cycles = cyc;
   endtask

   initial begin
      int cycles;
      rst = 1'b1; start = 1'b0; mode = 1'b0; exp_crc = 8'h00; abort = 1'b0;
      s_data = '0; s_valid = 1'b0;

      fork
         begin : monitor
            logic prev_end;
            prev_end = 1'b0;
            forever begin
               @(negedge clk);
               if (cfg_shift) begin
                  shift_cnt++;
                  if (exp_in_q.size() == 0) begin
                     n_cmp++; n_fail++;
                     $display("FAIL unexpected_shift: got data %0h expected no shift", cfg_data_in);
                  end else begin
                     chk("cfg_data_in", {28'd0, cfg_data_in}, {28'd0, exp_in_q.pop_front()});
                  end
               end
               if ((done || err) && !prev_end) begin
                  if (exp_stat_q.size() == 0) begin
                     n_cmp++; n_fail++;
                     $display("FAIL unexpected_status: got done=%0b err=%0b code=%0d expected none",
                              done, err, err_code);
                  end else begin
                     chk("status", {28'd0, done, err, err_code}, {28'd0, exp_stat_q.pop_front()});
                  end
               end
               prev_end = done || err;
            end
         end
         begin : watchdog
            #1_000_000;
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "timeout");
         end
      join_none

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_err", {31'd0, err}, 0);
      chk("rst_err_code", {30'd0, err_code}, 0);
      chk("rst_cfg_en", {31'd0, cfg_en}, 0);
      chk("rst_cfg_shift", {31'd0, cfg_shift}, 0);
      chk("rst_s_ready", {31'd0, s_ready}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // LOAD all 4'hA, correct CRC, back-to-back
      for (int i = 0; i < CL; i++) strm[i] = 4'hA;
      run_op(1'b0, crc_strm(), 4'b1000, 1, 0, 0, cycles);
      chk("b2b_cycles", cycles, CL + 2);

      // abort and start together while DONE: both ignored
      abort = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      chk("abort_in_done_ignored", {30'd0, done, busy}, 32'h2);

      // same stream, exp_crc bit 0 inverted
      run_op(1'b0, crc_strm() ^ 8'h01, 4'b0101, 1, 0, 0, cycles);

      // varied stream: LOAD then VERIFY
      for (int i = 0; i < CL; i++) strm[i] = 4'((i * 7 + 3) & 15);
      run_op(1'b0, crc_strm(), 4'b1000, 1, 0, 0, cycles);
      for (int k = 0; k < NC; k++) snap[k] = chain[k];
      run_op(1'b1, crc_strm(), 4'b1000, 1, 0, 0, cycles);
      chk("verify_chain_kept", {31'd0, chains_match()}, 1);

      // VERIFY with word 50 differing in bit 2, CRC correct for the stream sent
      strm[50] = strm[50] ^ 4'b0100;
      run_op(1'b1, crc_strm(), 4'b0110, 1, 0, 0, cycles);
      chk("verify_bad_chain_kept", {31'd0, chains_match()}, 1);
      strm[50] = strm[50] ^ 4'b0100;

      // s_valid every other cycle
      run_op(1'b0, crc_strm(), 4'b1000, 2, 0, 0, cycles);
      chk("half_rate_cycles", cycles, 2 * CL + 2);

      // abort after 30 transfers, then clean restart
      for (int i = 0; i < CL; i++) strm[i] = 4'hA;
      run_op(1'b0, crc_strm(), 4'b0111, 1, 30, 1, cycles);
      @(posedge clk); #1;
      run_op(1'b0, crc_strm(), 4'b1000, 1, 0, 0, cycles);

      // rst mid-LOAD
      run_op(1'b0, crc_strm(), 4'b0000, 1, 40, 2, cycles);

      repeat (3) @(posedge clk);
      #1;
      chk("queues_drained", exp_in_q.size() + exp_stat_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
